// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter and its neighbours in the
// divider chain.
package period_meter_pkg;

  typedef enum logic {
    WAIT_FIRST,
    COUNT
  } pm_state_e;

  localparam int unsigned PM_CNT_W = 32;

  // Board clock shared with Divider instances; EXPECT follows from it.
  localparam int unsigned BOARD_CLK_HZ = 50_000_000;
  localparam int unsigned PM_REF_HZ    = 10;
  localparam int unsigned PM_EXPECT    = BOARD_CLK_HZ / PM_REF_HZ;

endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizes an asynchronous input and emits a one-cycle rising-edge strobe.
// Reusable for push-button inputs.
module sig_sync_edge
  import period_meter_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic I_CLK,
  input  logic I_RST,
  input  logic I_SIG,
  output logic O_RISE
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Clearing to 0 makes a high input at reset release count as one rise.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], I_SIG};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign O_RISE = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/period_meter.sv
// Measures the rising-to-rising period of a slow asynchronous signal in clock
// cycles, flags a match against EXPECT +/- TOL, and detects a dead signal.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = PM_CNT_W,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 2 * PM_EXPECT,
  parameter int unsigned EXPECT      = PM_EXPECT,
  parameter int unsigned TOL         = 2
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_SIG,
  input  logic             I_CLR,
  output logic [CNT_W-1:0] O_PERIOD,
  output logic             O_VALID,
  output logic             O_MATCH,
  output logic             O_TIMEOUT
);

  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXPECT);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] dev;
  logic             rise;

  sig_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .I_CLK  (I_CLK),
    .I_RST  (I_RST),
    .I_SIG  (I_SIG),
    .O_RISE (rise)
  );

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q   <= WAIT_FIRST;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    timeout_d = timeout_q;
    cnt_inc   = cnt_q + CNT_W'(1);
    // Absolute deviation taken in the direction that cannot underflow.
    dev       = (cnt_inc >= EXP_C) ? (cnt_inc - EXP_C) : (EXP_C - cnt_inc);

    if (I_CLR) begin
      state_d   = WAIT_FIRST;
      cnt_d     = '0;
      period_d  = '0;
      match_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_FIRST: begin
          cnt_d = '0;
          if (rise) state_d = COUNT;
        end
        COUNT: begin
          // A rise on the timeout cycle wins and reports a period of TIMEOUT.
          if (rise) begin
            period_d  = cnt_inc;
            valid_d   = 1'b1;
            match_d   = (dev <= TOL_C);
            timeout_d = 1'b0;
            cnt_d     = '0;
          end else if (cnt_inc == TMO_C) begin
            timeout_d = 1'b1;
            match_d   = 1'b0;
            cnt_d     = '0;
            state_d   = WAIT_FIRST;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  assign O_PERIOD  = period_q;
  assign O_VALID   = valid_q;
  assign O_MATCH   = match_q;
  assign O_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: each driven rise that should complete a
// measurement pushes its expected period/match; the monitor pops on O_VALID.
module tb_period_meter;

  localparam int unsigned CW  = 16;
  localparam int unsigned EXP = 10;
  localparam int unsigned TL  = 1;
  localparam int unsigned TMO = 20;

  typedef struct {
    int unsigned per;
    bit          m;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig;
  logic          clr;
  logic [CW-1:0] period;
  logic          valid;
  logic          match;
  logic          tmo;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  int unsigned ncyc  = 0;
  int unsigned last_rise = 0;
  bit          armed = 1'b0;
  exp_t        sb[$];

  period_meter #(
    .CNT_W       (CW),
    .SYNC_STAGES (2),
    .TIMEOUT     (TMO),
    .EXPECT      (EXP),
    .TOL         (TL)
  ) dut (
    .I_CLK     (clk),
    .I_RST     (rst),
    .I_SIG     (sig),
    .I_CLR     (clr),
    .O_PERIOD  (period),
    .O_VALID   (valid),
    .O_MATCH   (match),
    .O_TIMEOUT (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  // Holds sig low for gap-1 cycles then high for one; models the measurement.
  task automatic send(input int unsigned gap);
    int unsigned g;
    exp_t e;
    repeat (gap - 1) begin
      tick();
      sig = 1'b0;
    end
    tick();
    sig = 1'b1;
    g = ncyc - last_rise;
    if (armed && g <= TMO) begin
      e.per = g;
      e.m   = ((g > EXP) ? (g - EXP) : (EXP - g)) <= TL;
      sb.push_back(e);
    end
    armed     = 1'b1;
    last_rise = ncyc;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Monitor: sample #1 after the active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", valid, 0);
      end else begin
        e = sb.pop_front();
        chk("period", period, e.per);
        chk("match", match, e.m);
        chk("timeout_on_valid", tmo, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    sig = 1'b0;
    clr = 1'b0;
    repeat (3) tick();
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_match", match, 0);
    chk("rst_timeout", tmo, 0);
    rst = 1'b0;

    // Steady period equal to EXPECT.
    send(3);
    repeat (4) send(10);
    // Tolerance boundaries and minimum period.
    send(12);
    send(11);
    send(9);
    send(8);
    send(2);
    send(10);
    drain();

    // Dead signal: timeout exactly 20 cycles after the measured rise.
    while (ncyc < last_rise + 22) tick();
    chk("tmo_early", tmo, 0);
    tick();
    chk("tmo_set", tmo, 1);
    chk("tmo_match", match, 0);
    chk("tmo_period_hold", period, 10);
    send(5);
    repeat (4) tick();
    chk("tmo_sticky", tmo, 1);
    send(10);
    drain();

    // Rise coincident with the timeout count.
    send(20);
    send(20);
    drain();
    chk("tmo_after_20", tmo, 0);

    // Clear on the same cycle as the internal rise.
    send(10);
    drain();
    tick(); sig = 1'b0;
    tick(); sig = 1'b1;
    tick(); sig = 1'b0;
    tick(); clr = 1'b1;
    tick(); clr = 1'b0;
    armed = 1'b0;
    chk("clr_period", period, 0);
    chk("clr_match", match, 0);
    chk("clr_timeout", tmo, 0);
    chk("clr_valid", valid, 0);
    repeat (3) tick();
    send(4);
    send(10);
    drain();

    // Asynchronous reset mid-count with sig high at release.
    send(10);
    drain();
    repeat (3) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    sig = 1'b1;
    #1;
    chk("arst_period", period, 0);
    chk("arst_match", match, 0);
    chk("arst_timeout", tmo, 0);
    chk("arst_valid", valid, 0);
    tick();
    tick();
    rst       = 1'b0;
    armed     = 1'b1;
    last_rise = ncyc;
    send(10);
    send(7);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
